data_memory_param: RTL and testbench



---
 rtl/data_memory_pkg.sv | 29 ++
 rtl/byte_lane_ram.sv | 97 +++++++++
 rtl/data_memory_param.sv | 151 +++++++++++++++
 tb/tb_data_memory_param.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_pkg
//  Description : Shared types, default sizes and the byte-merge helper for
//                the parametrised data memory. Optional macro:
//                DATA_MEMORY_PARITY_EN adds per-byte even parity.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_memory_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 8;

  // CLEAR zeroes the array after reset; READY serves requests.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // One byte of a write-first merge: the enabled new byte wins, otherwise the
  // stored byte is kept.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
    return be ? new_byte : old_byte;
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_lane_ram.sv
`default_nettype none
// ============================================================================
//  Module      : byte_lane_ram
//  Description : One byte-wide, DEPTH-deep synchronous RAM lane with its own
//                write enable and a registered, write-first read port.
//                Optional macro: DATA_MEMORY_PARITY_EN stores an even-parity
//                bit per entry and flags mismatches on read.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_ram
  import data_memory_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wdata,
  input  logic             re,
  input  logic             rd_zero,
  output logic [7:0]       rdata
`ifdef DATA_MEMORY_PARITY_EN
  ,
  output logic             par_err
`endif
);

`ifdef DATA_MEMORY_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif

  logic [LANE_W-1:0] mem_q [DEPTH];
  logic [LANE_W-1:0] mem_wword;
  logic [LANE_W-1:0] stored;
  logic [7:0]        rdata_q;
  logic [7:0]        rdata_d;
`ifdef DATA_MEMORY_PARITY_EN
  logic              par_err_q;
  logic              par_err_d;
`endif

  // Read-port next value: zero for out-of-range reads, merged word on a
  // simultaneous write, otherwise hold.
  always_comb begin
    stored  = mem_q[idx];
    rdata_d = rdata_q;
`ifdef DATA_MEMORY_PARITY_EN
    mem_wword = {^wdata, wdata};
    par_err_d = 1'b0;
`else
    mem_wword = wdata;
`endif
    if (rd_zero) begin
      rdata_d = 8'h00;
    end else if (re) begin
      rdata_d = byte_merge(stored[7:0], wdata, we);
`ifdef DATA_MEMORY_PARITY_EN
      // A freshly written byte carries fresh parity, so only stored bytes can
      // disagree.
      par_err_d = !we && (stored[8] != ^stored[7:0]);
`endif
    end
  end

  // Array write port; contents are deliberately not reset (the sweep clears).
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= mem_wword;
    end
  end

  // Registered read data (and parity strobe).
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q   <= 8'h00;
`ifdef DATA_MEMORY_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      rdata_q   <= rdata_d;
`ifdef DATA_MEMORY_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign rdata   = rdata_q;
`ifdef DATA_MEMORY_PARITY_EN
  assign par_err = par_err_q;
`endif

endmodule
`default_nettype wire

// File: rtl/data_memory_param.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_param
//  Description : Parametrised single-port data memory with per-byte write
//                enables, latency-1 registered read with valid strobe,
//                out-of-range detection and a post-reset clear sweep.
//                Optional macro: DATA_MEMORY_PARITY_EN adds the parity_err
//                output and per-byte parity storage.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_param
  import data_memory_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int ADDR_W = DEFAULT_ADDR_W,
  parameter  int DEPTH  = 256,
  localparam int NBYTES = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [NBYTES-1:0] byte_en,
  input  logic              memwrite,
  input  logic              memread,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              busy,
  output logic              addr_err
`ifdef DATA_MEMORY_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              read_valid_q, read_valid_d;
  logic              addr_err_q, addr_err_d;

  logic              in_range;
  logic [NBYTES-1:0] lane_we;
  logic [IDX_W-1:0]  lane_idx;
  logic [DATA_W-1:0] lane_wdata;
  logic              lane_re;
  logic              lane_rd_zero;
`ifdef DATA_MEMORY_PARITY_EN
  logic [NBYTES-1:0] lane_par_err;
`endif

  // Next-state and lane control: sweep in CLEAR, decode requests in READY.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    read_valid_d = 1'b0;
    addr_err_d   = 1'b0;
    lane_we      = '0;
    lane_idx     = addr[IDX_W-1:0];
    lane_wdata   = write_data;
    lane_re      = 1'b0;
    lane_rd_zero = 1'b0;
    in_range     = ({1'b0, addr} < DEPTH_EXT);

    unique case (state_q)
      CLEAR: begin
        // Requests are ignored; every lane writes zero at the sweep pointer.
        lane_we    = '1;
        lane_idx   = ptr_q;
        lane_wdata = '0;
        if (ptr_q == LAST_IDX) begin
          state_d = READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      READY: begin
        if (memread || memwrite) begin
          if (in_range) begin
            if (memwrite) begin
              lane_we = byte_en;
            end
            if (memread) begin
              lane_re      = 1'b1;
              read_valid_d = 1'b1;
            end
          end else begin
            addr_err_d = 1'b1;
            if (memread) begin
              lane_rd_zero = 1'b1;
              read_valid_d = 1'b1;
            end
          end
        end
      end
    endcase

    // No array writes on an edge that is resetting the control state.
    if (reset) begin
      lane_we = '0;
    end
  end

  // Control state register; reset restarts the clear sweep from entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR;
      ptr_q        <= '0;
      read_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      read_valid_q <= read_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  for (genvar i = 0; i < NBYTES; i++) begin : g_lane
    byte_lane_ram #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .we      (lane_we[i]),
      .idx     (lane_idx),
      .wdata   (lane_wdata[8*i +: 8]),
      .re      (lane_re),
      .rd_zero (lane_rd_zero),
      .rdata   (read_data[8*i +: 8])
`ifdef DATA_MEMORY_PARITY_EN
      ,
      .par_err (lane_par_err[i])
`endif
    );
  end

  assign read_valid = read_valid_q;
  assign addr_err   = addr_err_q;
  assign busy       = (state_q == CLEAR);
`ifdef DATA_MEMORY_PARITY_EN
  assign parity_err = |lane_par_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_memory_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_param
//  Description : Randomised scoreboard bench for data_memory_param (DEPTH=200
//                so the out-of-range window is reachable with 8-bit addresses).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;
  localparam int NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [NB-1:0]     byte_en;
  logic              memwrite;
  logic              memread;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              busy;
  logic              addr_err;
`ifdef DATA_MEMORY_PARITY_EN
  logic              parity_err;
`endif

  always #5 clk = ~clk;

  data_memory_param #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .write_data (write_data),
    .byte_en    (byte_en),
    .memwrite   (memwrite),
    .memread    (memread),
    .read_data  (read_data),
    .read_valid (read_valid),
    .busy       (busy),
    .addr_err   (addr_err)
`ifdef DATA_MEMORY_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  typedef struct {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [0:255];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain word array; whatever a request does to it is
  // decided here from the address range and byte mask alone.
  task automatic issue(input bit rd, input bit wr, input int a,
                       input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] old_w, new_w;
    @(negedge clk);
    memread    = rd;
    memwrite   = wr;
    addr       = a[7:0];
    write_data = wd;
    byte_en    = be;
    if (a < DEPTH) begin
      old_w = model[a];
      new_w = old_w;
      for (int i = 0; i < NB; i++) if (be[i]) new_w[8*i +: 8] = wd[8*i +: 8];
      if (wr) model[a] = new_w;
      if (rd) sb.push_back('{valid: 1'b1, err: 1'b0, data: (wr ? new_w : old_w)});
    end else if (rd || wr) begin
      sb.push_back('{valid: rd, err: 1'b1, data: 32'h0});
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      memread  = 1'b0;
      memwrite = 1'b0;
    end
  endtask

  // Throw random requests at the memory while it is sweeping; none may respond.
  task automatic drive_noise();
    memread    = 1'($urandom);
    memwrite   = 1'($urandom);
    addr       = 8'($urandom);
    write_data = $urandom;
    byte_en    = 4'($urandom);
  endtask

  // Release reset (at the current negedge) and count cycles until busy falls.
  task automatic release_and_count(input string name);
    int cnt;
    cnt   = 0;
    reset = 1'b0;
    do begin
      @(negedge clk);
      cnt++;
      if (busy) drive_noise();
      else begin
        memread  = 1'b0;
        memwrite = 1'b0;
      end
    end while (busy && cnt < 1000);
    check(name, cnt, DEPTH);
    for (int a = 0; a < 256; a++) model[a] = 32'h0;
  endtask

  // Monitor: compare every strobe against the scoreboard; between strobes the
  // read data must hold its last value.
  initial begin : monitor
    exp_t        e;
    logic [31:0] last;
    last = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        last = 32'h0;
        check("reset_read_data", read_data, 32'h0);
        check("reset_strobes", {30'h0, read_valid, addr_err}, 32'h0);
      end else if (read_valid || addr_err) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", {30'h0, read_valid, addr_err}, 32'h0);
        end else begin
          e = sb.pop_front();
          check("read_valid", read_valid, e.valid);
          check("addr_err", addr_err, e.err);
          if (e.valid) begin
            check("read_data", read_data, e.data);
            last = e.data;
`ifdef DATA_MEMORY_PARITY_EN
            check("parity_err", parity_err, 1'b0);
`endif
          end else begin
            check("hold_data", read_data, last);
          end
        end
      end else begin
        check("hold_data", read_data, last);
      end
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int r, a;
    reset      = 1'b1;
    memread    = 1'b0;
    memwrite   = 1'b0;
    addr       = '0;
    write_data = '0;
    byte_en    = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b1);
    release_and_count("busy_cycles_after_reset");

    // Directed scenarios.
    issue(1, 0, 8, 32'h0, 4'h0);
    issue(0, 1, 16, 32'h0000016A, 4'hF);
    issue(0, 1, 32, 32'h00000057, 4'hF);
    issue(1, 0, 16, 32'h0, 4'h0);
    issue(1, 0, 32, 32'h0, 4'h0);
    issue(0, 1, 5, 32'hAABBCCDD, 4'hF);
    issue(0, 1, 5, 32'h11223344, 4'b0101);
    issue(1, 0, 5, 32'h0, 4'h0);
    issue(0, 1, 7, 32'h12345678, 4'hF);
    issue(1, 1, 7, 32'hFFFFFFFF, 4'b0011);
    issue(1, 0, 7, 32'h0, 4'h0);
    issue(0, 1, 210, 32'hDEADBEEF, 4'hF);
    issue(1, 0, 210, 32'h0, 4'h0);
    issue(0, 1, 199, 32'hCAFEF00D, 4'hF);
    issue(1, 0, 199, 32'h0, 4'h0);
    issue(1, 1, 200, 32'h01020304, 4'hF);
    issue(0, 1, 5, 32'h99999999, 4'h0);
    issue(1, 0, 5, 32'h0, 4'h0);
    idle_cycles(3);

    // Randomised traffic, biased towards a few hot words and the range edge.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      a = $urandom_range(0, 15);
      else if (r < 8) a = $urandom_range(DEPTH - 4, DEPTH + 3);
      else            a = $urandom_range(0, 255);
      issue(1'($urandom), 1'($urandom), a, $urandom, 4'($urandom));
    end
    idle_cycles(3);

    // Reset in the middle of a sweep restarts it from the first entry.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      drive_noise();
    end
    reset = 1'b1;
    memread  = 1'b0;
    memwrite = 1'b0;
    @(negedge clk);
    check("midsweep_reset_busy", busy, 1'b1);
    release_and_count("busy_cycles_after_midsweep_reset");

    issue(1, 0, 16, 32'h0, 4'h0);
    issue(1, 0, 5, 32'h0, 4'h0);
    issue(1, 0, 199, 32'h0, 4'h0);
    issue(0, 1, 3, 32'h5A5A5A5A, 4'b1001);
    issue(1, 0, 3, 32'h0, 4'h0);
    idle_cycles(4);

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
